// File: rtl/sobol_pkg.sv
// rtl/sobol_pkg.sv - shared constants, state type and default direction vectors for the Sobol generator
package sobol_pkg;

  localparam int WIDTH  = 32;
  localparam int NUM_DV = 32;
  localparam int LEN_W  = 32;
  localparam int DV_AW  = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sobol_state_t;

  // Dimension-1 (van der Corput) vector k: a single bit walking down from the MSB.
  function automatic logic [WIDTH-1:0] default_dv(input int unsigned k);
    logic [WIDTH-1:0] msb;
    msb = {1'b1, {(WIDTH-1){1'b0}}};
    return msb >> k;
  endfunction

endpackage

// File: rtl/sobol_lowzero_enc.sv
// rtl/sobol_lowzero_enc.sv - lowest-zero-bit priority encoder selecting the direction vector
import sobol_pkg::*;

module sobol_lowzero_enc (
  input  logic [LEN_W-1:0] i_n,
  output logic [DV_AW-1:0] o_c
);

  // Scan from MSB down so the last hit (the lowest zero) wins.
  always_comb begin
    o_c = '0;
    for (int i = LEN_W - 1; i >= 0; i--) begin
      if (!i_n[i]) begin
        o_c = DV_AW'(i);
      end
    end
  end

endmodule

// File: rtl/sobol_int32_gen.sv
// rtl/sobol_int32_gen.sv - single-dimension Gray-code Sobol sequence generator with loadable vectors
import sobol_pkg::*;

module sobol_int32_gen (
  input  logic             clk,
  input  logic             rst,
  input  logic             dv_wr_en,
  input  logic [DV_AW-1:0] dv_wr_addr,
  input  logic [WIDTH-1:0] dv_wr_data,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [LEN_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  sobol_state_t     r_state;
  logic [WIDTH-1:0] r_dv [NUM_DV];
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_n;
  logic [WIDTH-1:0] r_x;
  logic             r_out_valid;
  logic             r_done;

  logic [DV_AW-1:0] w_c;
  logic             w_xfer;
  logic             w_last;
  logic             w_dv_we;

  // c is taken from the current index n, which is (n+1)-1 for the next sample.
  sobol_lowzero_enc u_enc (
    .i_n (r_n),
    .o_c (w_c)
  );

  assign w_xfer  = r_out_valid & out_ready;
  assign w_last  = (r_n == r_len);
  assign w_dv_we = dv_wr_en & (r_state == IDLE);

  // Direction-vector table: restored to van der Corput on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DV; k++) begin
        r_dv[k] <= default_dv(k);
      end
    end else if (w_dv_we) begin
      r_dv[dv_wr_addr] <= dv_wr_data;
    end
  end

  // Run control: start a run from idle, step the recurrence on each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_n         <= '0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // The done cycle is still idle, but start is not accepted until the cycle after.
          if (start && !r_done) begin
            if (run_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_len       <= run_len;
              r_n         <= LEN_W'(1);
              r_x         <= r_dv[0];
              r_out_valid <= 1'b1;
              r_state     <= RUN;
            end
          end
        end
        RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_n <= r_n + LEN_W'(1);
              r_x <= r_x ^ r_dv[w_c];
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_val   = r_x;
  assign out_idx   = r_n;
  assign busy      = (r_state == RUN);
  assign done      = r_done;

endmodule

// File: tb/tb_sobol_int32_gen.sv
// tb/tb_sobol_int32_gen.sv - randomized self-checking bench for the Sobol generator
module tb_sobol_int32_gen;

  localparam int W  = 32;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dv_wr_en = 1'b0;
  logic [4:0]    dv_wr_addr = '0;
  logic [W-1:0]  dv_wr_data = '0;
  logic          start = 1'b0;
  logic [LW-1:0] run_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_val;
  logic [LW-1:0] out_idx;
  logic          busy;
  logic          done;

  logic [W-1:0]  mv [32];
  int            n_checks = 0;
  int            n_fail = 0;

  sobol_int32_gen dut (
    .clk        (clk),
    .rst        (rst),
    .dv_wr_en   (dv_wr_en),
    .dv_wr_addr (dv_wr_addr),
    .dv_wr_data (dv_wr_data),
    .start      (start),
    .run_len    (run_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_val    (out_val),
    .out_idx    (out_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Closed form: x_n is the XOR of v[k] over the set bits of gray(n).
  function automatic logic [W-1:0] sobol_ref(input logic [LW-1:0] n);
    logic [LW-1:0] g;
    logic [W-1:0]  x;
    g = n ^ (n >> 1);
    x = '0;
    for (int k = 0; k < 32; k++) begin
      if (g[k]) x = x ^ mv[k];
    end
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mv[k] = 32'h8000_0000 >> k;
  endtask

  task automatic write_dv(input int k, input logic [W-1:0] d);
    @(negedge clk);
    dv_wr_en = 1'b1;
    dv_wr_addr = 5'(k);
    dv_wr_data = d;
    @(negedge clk);
    dv_wr_en = 1'b0;
    mv[k] = d;
  endtask

  task automatic run(input int len, input int ready_pct, input bit inject,
                     input int rst_at, input bit start_in_done, input int stall_at);
    int idx;
    int cyc;
    int stalls;
    @(negedge clk);
    start = 1'b1;
    run_len = LW'(len);
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      check("zl_valid", out_valid, 0);
      check("zl_done", done, 1);
      check("zl_busy", busy, 0);
      @(negedge clk);
      check("zl_done_clr", done, 0);
      check("zl_valid2", out_valid, 0);
      return;
    end
    idx = 1;
    cyc = 0;
    stalls = 0;
    while (idx <= len && cyc < len * 40 + 100) begin
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("done_low", done, 0);
      check("idx", out_idx, idx);
      check("val", out_val, sobol_ref(LW'(idx)));
      if (rst_at == idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        model_reset();
        return;
      end
      if (inject && idx == 2) begin
        start = 1'b1;
        run_len = 7;
        dv_wr_en = 1'b1;
        dv_wr_addr = 5'd0;
        dv_wr_data = '1;
      end else begin
        start = 1'b0;
        dv_wr_en = 1'b0;
      end
      if (idx == stall_at && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      if (out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    dv_wr_en = 1'b0;
    check("end_idx", idx, len + 1);
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    if (start_in_done) begin
      start = 1'b1;
      run_len = 5;
    end
    @(negedge clk);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_valid", out_valid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_val", out_val, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    rst = 1'b0;

    // Default table, full throughput.
    run(4, 100, 1'b0, 0, 1'b0, 0);
    // Loaded vectors.
    write_dv(0, 32'h0000_0001);
    write_dv(1, 32'h0000_0003);
    run(3, 100, 1'b0, 0, 1'b0, 0);
    write_dv(0, 32'h8000_0000);
    write_dv(1, 32'h4000_0000);
    // Backpressure on sample 2.
    run(4, 100, 1'b0, 0, 1'b0, 2);
    // Zero-length run.
    run(0, 100, 1'b0, 0, 1'b0, 0);
    // start and dv write during RUN ignored; start in done cycle ignored.
    run(5, 100, 1'b1, 0, 1'b1, 0);
    // Reset mid-run restores the table.
    write_dv(0, 32'h1234_5678);
    run(10, 100, 1'b0, 3, 1'b0, 0);
    run(1, 100, 1'b0, 0, 1'b0, 0);
    // Longer run exercises higher direction-vector indices.
    run(200, 100, 1'b0, 0, 1'b0, 0);

    // Randomized tables, lengths and backpressure.
    for (int t = 0; t < 12; t++) begin
      int nw;
      nw = $urandom_range(3);
      for (int w = 0; w < nw; w++) begin
        write_dv($urandom_range(31), $urandom);
      end
      run($urandom_range(24), $urandom_range(100, 30), 1'(t % 3 == 0), 0,
          1'($urandom_range(1)), $urandom_range(6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
